// File: rtl/ram_access_ctrl.sv
// MEM-stage initiator for a word-addressed, async-read, level-write data RAM.
// Handles byte/half/word loads and stores, with read-modify-write for sub-word stores.
module ram_access_ctrl #(
  parameter int DEPTH = 2048,
  parameter int IDX_W = 11
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic        i_req_we,
  input  logic [1:0]  i_req_size,
  input  logic        i_req_signed,
  input  logic [31:0] i_req_addr,
  input  logic [31:0] i_req_wdata,
  output logic        o_resp_valid,
  input  logic        i_resp_ready,
  output logic [31:0] o_resp_rdata,
  output logic        o_resp_err,
  output logic        o_ram_re,
  output logic [31:0] o_ram_raddr,
  input  logic [31:0] i_ram_rdata,
  output logic        o_ram_we,
  output logic [31:0] o_ram_waddr,
  output logic [31:0] o_ram_wdata
);

  localparam logic [32:0] ADDR_LIM = 33'(4 * DEPTH);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_RMWR = 3'd2,
    S_WR   = 3'd3,
    S_RMWW = 3'd4,
    S_RESP = 3'd5
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  logic [1:0]  r_size;
  logic [1:0]  r_lane;
  logic        r_signed;
  logic [31:0] r_wdata;
  logic        r_req_ready;
  logic        r_resp_valid;
  logic [31:0] r_resp_rdata;
  logic        r_resp_err;
  logic        r_ram_re;
  logic [31:0] r_ram_raddr;
  logic        r_ram_we;
  logic [31:0] r_ram_waddr;
  logic [31:0] r_ram_wdata;

  logic             w_accept;
  logic             w_req_err;
  logic [IDX_W-1:0] w_idx;
  logic [31:0]      w_idx_ext;
  logic             w_ram_re_nxt;
  logic             w_ram_we_nxt;
  logic             w_resp_valid_nxt;
  logic             w_req_ready_nxt;
  logic [31:0]      w_load_data;
  logic [31:0]      w_merged;

  // Selects the addressed lane(s) of a RAM word and sign/zero-extends them.
  function automatic logic [31:0] f_extract(input logic [31:0] word, input logic [1:0] size,
                                            input logic [1:0] lane, input logic sgn);
    logic [31:0] sh;
    sh = word >> {lane, 3'b000};
    case (size)
      2'd0:    f_extract = {{24{sgn & sh[7]}}, sh[7:0]};
      2'd1:    f_extract = {{16{sgn & sh[15]}}, sh[15:0]};
      default: f_extract = word;
    endcase
  endfunction

  function automatic logic [31:0] f_merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [1:0] size, input logic [1:0] lane);
    logic [31:0] mask;
    case (size)
      2'd0:    mask = 32'h0000_00FF << {lane, 3'b000};
      2'd1:    mask = 32'h0000_FFFF << {lane, 3'b000};
      default: mask = 32'hFFFF_FFFF;
    endcase
    f_merge = (old & ~mask) | ((wd << {lane, 3'b000}) & mask);
  endfunction

  assign w_accept  = i_req_valid && (r_state == S_IDLE);
  assign w_idx     = i_req_addr[IDX_W+1:2];
  assign w_idx_ext = {{(32-IDX_W){1'b0}}, w_idx};
  assign w_req_err = ((i_req_size == 2'd1) && i_req_addr[0])
                  || ((i_req_size == 2'd2) && (i_req_addr[1:0] != 2'd0))
                  || (i_req_size == 2'd3)
                  || ({1'b0, i_req_addr} >= ADDR_LIM);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (!w_accept)                 w_state_nxt = S_IDLE;
        else if (w_req_err)            w_state_nxt = S_RESP;
        else if (!i_req_we)            w_state_nxt = S_RD;
        else if (i_req_size == 2'd2)   w_state_nxt = S_WR;
        else                           w_state_nxt = S_RMWR;
      end
      S_RD:   w_state_nxt = S_RESP;
      S_RMWR: w_state_nxt = S_RMWW;
      S_WR:   w_state_nxt = S_RESP;
      S_RMWW: w_state_nxt = S_RESP;
      S_RESP: begin
        if (i_resp_ready) w_state_nxt = S_IDLE;
        else              w_state_nxt = S_RESP;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so every RAM strobe comes straight off a flop.
  always_comb begin
    w_ram_re_nxt     = (w_state_nxt == S_RD) || (w_state_nxt == S_RMWR);
    w_ram_we_nxt     = (w_state_nxt == S_WR) || (w_state_nxt == S_RMWW);
    w_resp_valid_nxt = (w_state_nxt == S_RESP);
    w_req_ready_nxt  = (w_state_nxt == S_IDLE);
    w_load_data      = f_extract(i_ram_rdata, r_size, r_lane, r_signed);
    w_merged         = f_merge(i_ram_rdata, r_wdata, r_size, r_lane);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_size       <= 2'd0;
      r_lane       <= 2'd0;
      r_signed     <= 1'b0;
      r_wdata      <= 32'd0;
      r_req_ready  <= 1'b1;
      r_resp_valid <= 1'b0;
      r_resp_rdata <= 32'd0;
      r_resp_err   <= 1'b0;
      r_ram_re     <= 1'b0;
      r_ram_raddr  <= 32'd0;
      r_ram_we     <= 1'b0;
      r_ram_waddr  <= 32'd0;
      r_ram_wdata  <= 32'd0;
    end else begin
      r_ram_re     <= w_ram_re_nxt;
      r_ram_we     <= w_ram_we_nxt;
      r_resp_valid <= w_resp_valid_nxt;
      r_req_ready  <= w_req_ready_nxt;
      if (w_accept) begin
        r_size       <= i_req_size;
        r_lane       <= i_req_addr[1:0];
        r_signed     <= i_req_signed;
        r_wdata      <= i_req_wdata;
        r_resp_err   <= w_req_err;
        r_resp_rdata <= 32'd0;
        r_ram_raddr  <= w_idx_ext;
      end
      // Write address/data move only on the edge that raises ram_we, then hold.
      if (w_accept && (w_state_nxt == S_WR)) begin
        r_ram_waddr <= w_idx_ext;
        r_ram_wdata <= i_req_wdata;
      end
      if (r_state == S_RMWR) begin
        r_ram_waddr <= r_ram_raddr;
        r_ram_wdata <= w_merged;
      end
      if (r_state == S_RD) begin
        r_resp_rdata <= w_load_data;
      end
    end
  end

  assign o_req_ready  = r_req_ready;
  assign o_resp_valid = r_resp_valid;
  assign o_resp_rdata = r_resp_rdata;
  assign o_resp_err   = r_resp_err;
  assign o_ram_re     = r_ram_re;
  assign o_ram_raddr  = r_ram_raddr;
  assign o_ram_we     = r_ram_we;
  assign o_ram_waddr  = r_ram_waddr;
  assign o_ram_wdata  = r_ram_wdata;

endmodule
